// File: rtl/half_rate_packer.sv
// half_rate_packer: fast-to-slow width gearbox.
// Accepts WIDTH-bit beats on clk_i into a DEPTH-entry FIFO and packs
// pairs of beats into 2*WIDTH-bit words. The output registers only
// change on edges where phase_i is high, so a consumer clocked by the
// divided clock (rising while phase_i is low) always sees a stable word.
// Optional feature: define HALF_RATE_PACKER_FLUSH_EN to add flush_i and
// out_half_o, which let a lone buffered beat be emitted as a half word.
module half_rate_packer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               phase_i,
`ifdef HALF_RATE_PACKER_FLUSH_EN
    input  logic               flush_i,
    output logic               out_half_o,
`endif
    input  logic [WIDTH-1:0]   in_data_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic [2*WIDTH-1:0] out_data_o,
    output logic               out_valid_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_TWO  = (PTR_W+1)'(2);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_TWO  = PTR_W'(2);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt1;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_nxt;
    logic             push;
    logic             pop_pair;
    logic             pop_single;

    // Ready reflects the pre-edge occupancy only; a same-edge pop is ignored.
    assign in_ready_o  = (count < CNT_FULL);
    assign push        = in_valid_i & in_ready_o;
    assign pop_pair    = phase_i && (count >= CNT_TWO);
    assign rd_ptr_nxt1 = rd_ptr + PTR_ONE;

`ifdef HALF_RATE_PACKER_FLUSH_EN
    assign pop_single  = phase_i && flush_i && (count == CNT_ONE);
`else
    assign pop_single  = 1'b0;
`endif

    // Occupancy bookkeeping: +1 per accepted beat, -2 per pair, -1 per flush.
    always_comb begin
        count_nxt = count;
        if (push) begin
            count_nxt = count_nxt + CNT_ONE;
        end
        if (pop_pair) begin
            count_nxt = count_nxt - CNT_TWO;
        end else if (pop_single) begin
            count_nxt = count_nxt - CNT_ONE;
        end
    end

    // Beat storage; the slot at wr_ptr is never one being popped this edge.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= in_data_i;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_pair) begin
                rd_ptr <= rd_ptr + PTR_TWO;
            end else if (pop_single) begin
                rd_ptr <= rd_ptr_nxt1;
            end
        end
    end

    // Output word: loaded or invalidated on update edges only, held otherwise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_data_o  <= '0;
            out_valid_o <= 1'b0;
        end else if (phase_i) begin
            if (pop_pair) begin
                out_data_o  <= {mem[rd_ptr_nxt1], mem[rd_ptr]};
                out_valid_o <= 1'b1;
            end else if (pop_single) begin
                out_data_o  <= {{WIDTH{1'b0}}, mem[rd_ptr]};
                out_valid_o <= 1'b1;
            end else begin
                out_valid_o <= 1'b0;
            end
        end
    end

`ifdef HALF_RATE_PACKER_FLUSH_EN
    // Half-word marker, refreshed on every update edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_half_o <= 1'b0;
        end else if (phase_i) begin
            out_half_o <= pop_single;
        end
    end
`endif

endmodule

// File: tb/tb_half_rate_packer.sv
// Directed testbench for half_rate_packer (WIDTH=8, DEPTH=4).
module tb_half_rate_packer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        phase_i = 1'b0;
    logic [7:0]  in_data_i = '0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [15:0] out_data_o;
    logic        out_valid_o;
`ifdef HALF_RATE_PACKER_FLUSH_EN
    logic        flush_i = 1'b0;
    logic        out_half_o;
`endif

    int total = 0;
    int bad   = 0;

    half_rate_packer #(.WIDTH(8), .DEPTH(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .phase_i     (phase_i),
`ifdef HALF_RATE_PACKER_FLUSH_EN
        .flush_i     (flush_i),
        .out_half_o  (out_half_o),
`endif
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One edge with given phase and optional beat.
    task automatic step(input logic ph, input logic vld, input logic [7:0] d);
        phase_i    = ph;
        in_valid_i = vld;
        in_data_i  = d;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset asserted between edges
        #2 rst_i = 1'b1;
        #1;
        check("rst_data", 32'(out_data_o), 32'h0);
        check("rst_valid", 32'(out_valid_o), 32'h0);
        check("rst_ready", 32'(in_ready_o), 32'h1);
`ifdef HALF_RATE_PACKER_FLUSH_EN
        check("rst_half", 32'(out_half_o), 32'h0);
`endif
        tick();
        tick();
        rst_i = 1'b0;

        // Basic pack: A at phase 0, B at phase 1, word after the next update edge
        step(1'b0, 1'b1, 8'h11);
        step(1'b1, 1'b1, 8'h22);
        step(1'b0, 1'b0, 8'h00);
        check("basic_early_valid", 32'(out_valid_o), 32'h0);
        step(1'b1, 1'b0, 8'h00);
        check("basic_data", 32'(out_data_o), 32'h2211);
        check("basic_valid", 32'(out_valid_o), 32'h1);
        step(1'b0, 1'b0, 8'h00);
        check("basic_hold_data", 32'(out_data_o), 32'h2211);
        check("basic_hold_valid", 32'(out_valid_o), 32'h1);
        step(1'b1, 1'b0, 8'h00);
        check("basic_end_valid", 32'(out_valid_o), 32'h0);
        check("basic_end_data", 32'(out_data_o), 32'h2211);

        // Streaming 0x01..0x10 with phase alternating from 0
        for (int k = 0; k < 20; k++) begin
            if (k < 16) begin
                check($sformatf("stream_ready_%0d", k), 32'(in_ready_o), 32'h1);
                step(1'(k % 2), 1'b1, 8'(k + 1));
            end else begin
                step(1'(k % 2), 1'b0, 8'h00);
            end
            if ((k % 2 == 1) && k >= 3 && k <= 17) begin
                check($sformatf("stream_word_%0d", k), 32'(out_data_o),
                      32'({8'(k - 1), 8'(k - 2)}));
                check($sformatf("stream_valid_%0d", k), 32'(out_valid_o), 32'h1);
            end
        end
        check("stream_drained_valid", 32'(out_valid_o), 32'h0);

        // Full: four beats with phase held low
        step(1'b0, 1'b1, 8'hA0);
        step(1'b0, 1'b1, 8'hA1);
        step(1'b0, 1'b1, 8'hA2);
        check("full_ready_3", 32'(in_ready_o), 32'h1);
        step(1'b0, 1'b1, 8'hA3);
        check("full_ready", 32'(in_ready_o), 32'h0);
        step(1'b0, 1'b1, 8'hA4);
        check("full_ready_held", 32'(in_ready_o), 32'h0);
        check("full_no_output", 32'(out_valid_o), 32'h0);
        step(1'b1, 1'b1, 8'hA4);
        check("full_pop_data", 32'(out_data_o), 32'hA1A0);
        check("full_pop_valid", 32'(out_valid_o), 32'h1);
        check("full_ready_after_pop", 32'(in_ready_o), 32'h1);
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        check("full_pop2_data", 32'(out_data_o), 32'hA3A2);
        step(1'b0, 1'b1, 8'hB0);
        step(1'b1, 1'b1, 8'hB1);
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        check("full_fifth_dropped", 32'(out_data_o), 32'hB1B0);
        check("full_fifth_valid", 32'(out_valid_o), 32'h1);

        // Mid-stream reset with three beats buffered
        step(1'b0, 1'b1, 8'hC0);
        step(1'b0, 1'b1, 8'hC1);
        step(1'b0, 1'b1, 8'hC2);
        in_valid_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        check("mrst_data", 32'(out_data_o), 32'h0);
        check("mrst_valid", 32'(out_valid_o), 32'h0);
        check("mrst_ready", 32'(in_ready_o), 32'h1);
        tick();
        rst_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1'(k % 2), 1'b0, 8'h00);
            check($sformatf("mrst_no_stale_%0d", k), 32'(out_valid_o), 32'h0);
        end
        step(1'b0, 1'b1, 8'hD0);
        step(1'b1, 1'b1, 8'hD1);
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        check("mrst_fresh_data", 32'(out_data_o), 32'hD1D0);
        check("mrst_fresh_valid", 32'(out_valid_o), 32'h1);
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);

`ifdef HALF_RATE_PACKER_FLUSH_EN
        // Lone beat flushed as a half word
        flush_i = 1'b1;
        step(1'b0, 1'b1, 8'hAB);
        step(1'b1, 1'b0, 8'h00);
        check("flush_data", 32'(out_data_o), 32'h00AB);
        check("flush_valid", 32'(out_valid_o), 32'h1);
        check("flush_half", 32'(out_half_o), 32'h1);
        flush_i = 1'b0;
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        check("flush_after_half", 32'(out_half_o), 32'h0);
        check("flush_after_valid", 32'(out_valid_o), 32'h0);
`else
        // Lone beat waits for its partner
        step(1'b0, 1'b1, 8'hAB);
        step(1'b1, 1'b0, 8'h00);
        check("lone_wait_valid", 32'(out_valid_o), 32'h0);
        step(1'b0, 1'b1, 8'hCD);
        step(1'b1, 1'b0, 8'h00);
        check("lone_pair_data", 32'(out_data_o), 32'hCDAB);
        check("lone_pair_valid", 32'(out_valid_o), 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
